mem_lat_hs: RTL

Parametrised two-port main memory with valid/ready request/response handshakes, programmable access latency and error reporting, replacing the zero-latency combinational memory on the CPU's instruction and data paths. One read-only instruction port and one read/write data port share a single word array. The block supports byte, halfword and word accesses with sign or zero extension. It also models multi-cycle memory so the pipeline's stall logic can be exercised.

---
 rtl/mem_pkg.sv | 63 ++++++
 rtl/mem_port_ctl.sv | 63 ++++++
 rtl/mem_lat_hs.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and load/store lane helpers for the
// latency-modelling two-port main memory.
package mem_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;
    localparam int         MEM_UNSIGNED = 2;   // bit index in the 3-bit type field

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } port_state_t;

    // Select the byte/half addressed by off from a word, then extend.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [1:0]  off,
                                                input logic [2:0]  typ);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (typ[1:0])
            MEM_B:   r = typ[MEM_UNSIGNED] ? {24'b0, b} : {{24{b[7]}}, b};
            MEM_H:   r = typ[MEM_UNSIGNED] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size,
                                            input logic [1:0] off);
        logic [3:0] be;
        case (size)
            MEM_B:   be = 4'b0001 << off;
            MEM_H:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the LSB-aligned store data onto every lane it could occupy.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            MEM_B:   r = {4{wd[7:0]}};
            MEM_H:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_port_ctl.sv
// Per-port valid/ready handshake FSM with latency counter and request latch.
// exec pulses for exactly one cycle per accepted request.
module mem_port_ctl
    import mem_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1,
    parameter int PW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [PW-1:0] req_payload,
    output logic [PW-1:0] payload_q,
    output logic          exec,
    output logic          rsp_valid,
    input  logic          rsp_ready
);

    localparam logic [CNT_W-1:0] RD_M1 = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_M1 = CNT_W'(WR_LAT - 1);

    port_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [PW-1:0]    payload_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            payload_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && req_valid) begin
                cnt_reg     <= req_we ? WR_M1 : RD_M1;
                payload_reg <= req_payload;
            end else if (state_reg == ST_BUSY && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (req_valid)       state_next = ST_BUSY;
            ST_BUSY: if (cnt_reg == '0)   state_next = ST_RESP;
            ST_RESP: if (rsp_ready)       state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_reg == ST_IDLE);
        exec      = (state_reg == ST_BUSY) && (cnt_reg == '0);
        rsp_valid = (state_reg == ST_RESP);
    end

    assign payload_q = payload_reg;

endmodule

// File: rtl/mem_lat_hs.sv
// Two-port main memory: read-only instruction port and read/write data port
// sharing one word array, each with a programmable-latency handshake.
module mem_lat_hs
    import mem_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH_W   = 17,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
    parameter int                RD_LAT    = 2,
    parameter int                WR_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       i_rsp_data,
    output logic              i_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [2:0]        d_req_type,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [31:0]       d_rsp_rdata,
    output logic              d_rsp_err
);

    localparam int DEPTH = 1 << DEPTH_W;
    localparam int DPW   = 1 + 3 + ADDR_W + 32;

    logic [31:0] mem [0:DEPTH-1];

    logic              i_exec, d_exec;
    logic [ADDR_W-1:0] i_addr_q, d_addr_q;
    logic [DPW-1:0]    d_payload_q;
    logic              d_we_q;
    logic [2:0]        d_type_q;
    logic [31:0]       d_wdata_q;

    mem_port_ctl #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .PW(ADDR_W)) u_i_ctl (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (i_req_valid),
        .req_ready   (i_req_ready),
        .req_we      (1'b0),
        .req_payload (i_req_addr),
        .payload_q   (i_addr_q),
        .exec        (i_exec),
        .rsp_valid   (i_rsp_valid),
        .rsp_ready   (i_rsp_ready)
    );

    mem_port_ctl #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .PW(DPW)) u_d_ctl (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (d_req_valid),
        .req_ready   (d_req_ready),
        .req_we      (d_req_we),
        .req_payload ({d_req_we, d_req_type, d_req_addr, d_req_wdata}),
        .payload_q   (d_payload_q),
        .exec        (d_exec),
        .rsp_valid   (d_rsp_valid),
        .rsp_ready   (d_rsp_ready)
    );

    assign {d_we_q, d_type_q, d_addr_q, d_wdata_q} = d_payload_q;

    // BASE_ADDR is word-aligned, so the offset's low bits equal the address's.
    logic [ADDR_W-1:0]  i_off, d_off;
    logic [DEPTH_W-1:0] i_idx, d_idx;
    logic               i_err, d_err, d_mis;
    logic [1:0]         d_size;

    assign i_off  = i_addr_q - BASE_ADDR;
    assign d_off  = d_addr_q - BASE_ADDR;
    assign i_idx  = i_off[DEPTH_W+1:2];
    assign d_idx  = d_off[DEPTH_W+1:2];
    assign d_size = d_type_q[1:0];

    assign i_err = (i_addr_q < BASE_ADDR)
                || (i_off[ADDR_W-1:DEPTH_W+2] != '0)
                || (i_off[1:0] != 2'b00);

    assign d_mis = ((d_size == MEM_H) && d_off[0])
                || (d_size[1] && (d_off[1:0] != 2'b00));

    assign d_err = (d_addr_q < BASE_ADDR)
                || (d_off[ADDR_W-1:DEPTH_W+2] != '0)
                || d_mis;

    logic [3:0]  d_be;
    logic [31:0] d_lanes;
    assign d_be    = store_be(d_size, d_off[1:0]);
    assign d_lanes = store_lanes(d_size, d_wdata_q);

    // Registered reads on the execute edge; a same-edge store is not yet
    // visible to them, which gives the fetch its pre-store value.
    logic [31:0] i_word_reg, d_word_reg;

    always_ff @(posedge clk) begin
        if (i_exec)
            i_word_reg <= mem[i_idx];
        if (d_exec)
            d_word_reg <= mem[d_idx];
        if (d_exec && d_we_q && !d_err) begin
            for (int b = 0; b < 4; b++) begin
                if (d_be[b])
                    mem[d_idx][8*b +: 8] <= d_lanes[8*b +: 8];
            end
        end
    end

    logic i_ok_reg, i_err_reg, d_ok_reg, d_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_ok_reg  <= 1'b0;
            i_err_reg <= 1'b0;
            d_ok_reg  <= 1'b0;
            d_err_reg <= 1'b0;
        end else begin
            if (i_exec) begin
                i_ok_reg  <= !i_err;
                i_err_reg <= i_err;
            end
            if (d_exec) begin
                d_ok_reg  <= !d_err && !d_we_q;
                d_err_reg <= d_err;
            end
        end
    end

    // Latched address/type hold through RESP, so the extended data stays stable.
    assign i_rsp_data  = i_ok_reg ? i_word_reg : '0;
    assign i_rsp_err   = i_err_reg;
    assign d_rsp_rdata = d_ok_reg ? load_extend(d_word_reg, d_off[1:0], d_type_q) : '0;
    assign d_rsp_err   = d_err_reg;

endmodule
